// File: rtl/apa102_out.sv
// APA102 frame transmitter: 32-bit zero start frame, seven LED frames, 32-bit ones end frame.
// Define APA102_OUT_HDR_FORCE_EN to force bits [31:29] of every LED frame to 3'b111.
module apa102_out #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [223:0] data_in,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         sck,
    output logic         sda
);

    typedef enum logic [1:0] {IDLE, START_FRAME, DATA, END_FRAME} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [8:0] LAST_BIT = 9'd287;

`ifdef APA102_OUT_HDR_FORCE_EN
    localparam logic [223:0] HDR_MASK = {7{32'hE000_0000}};
`else
    localparam logic [223:0] HDR_MASK = '0;
`endif

    state_t         state_q;
    logic   [7:0]   div_q;
    logic   [8:0]   bit_q;
    logic   [223:0] shift_q;
    logic           sck_q;
    logic           sda_q;
    logic           busy_q;
    logic           done_q;

    state_t         state_d;
    logic   [8:0]   bit_d;
    logic           sda_d;

    // Frame segment and data bit for the bit that follows the current one.
    always_comb begin
        bit_d = bit_q + 9'd1;
        if (bit_d >= 9'd256) begin
            sda_d   = 1'b1;
            state_d = END_FRAME;
        end else if (bit_d >= 9'd32) begin
            sda_d   = shift_q[223];
            state_d = DATA;
        end else begin
            sda_d   = 1'b0;
            state_d = START_FRAME;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            sck_q   <= 1'b0;
            sda_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        shift_q <= data_in | HDR_MASK;
                        state_q <= START_FRAME;
                        div_q   <= '0;
                        bit_q   <= '0;
                        sck_q   <= 1'b0;
                        sda_q   <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                default: begin
                    if (div_q != DIV_LAST) begin
                        div_q <= div_q + 8'd1;
                    end else begin
                        div_q <= '0;
                        if (!sck_q) begin
                            sck_q <= 1'b1;
                        end else begin
                            // End of a high phase: sda only ever moves here, keeping it stable while sck is high.
                            sck_q <= 1'b0;
                            if (bit_q == LAST_BIT) begin
                                state_q <= IDLE;
                                bit_q   <= '0;
                                sda_q   <= 1'b0;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                bit_q   <= bit_d;
                                sda_q   <= sda_d;
                                state_q <= state_d;
                                if (state_d == DATA) begin
                                    shift_q <= {shift_q[222:0], 1'b0};
                                end
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sck  = sck_q;
    assign sda  = sda_q;

endmodule

// File: tb/tb_apa102_out.sv
// Bench for apa102_out: scoreboard of expected 32-bit words checked against sda sampled on sck rises.
// Expectations follow APA102_OUT_HDR_FORCE_EN when it is defined for the build.
module tb_apa102_out;

    localparam int A_DIV = 2;
    localparam int B_DIV = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [223:0] data_a, data_b;
    logic         start_a, start_b;
    logic         busy_a, done_a, sck_a, sda_a;
    logic         busy_b, done_b, sck_b, sda_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] q_a[$];
    logic [31:0] q_b[$];

    always #5 clk = ~clk;

    apa102_out #(.CLK_DIV(A_DIV)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(data_a), .start(start_a),
        .busy(busy_a), .done(done_a), .sck(sck_a), .sda(sda_a)
    );

    apa102_out #(.CLK_DIV(B_DIV)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(data_b), .start(start_b),
        .busy(busy_b), .done(done_b), .sck(sck_b), .sda(sda_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_led(input logic [31:0] w);
`ifdef APA102_OUT_HDR_FORCE_EN
        return w | 32'hE000_0000;
`else
        return w;
`endif
    endfunction

    task automatic push_frame(input logic [223:0] d, input bit to_b);
        logic [31:0] w;
        if (to_b) q_b.push_back(32'h0); else q_a.push_back(32'h0);
        for (int i = 0; i < 7; i++) begin
            w = exp_led(d[223 - 32*i -: 32]);
            if (to_b) q_b.push_back(w); else q_a.push_back(w);
        end
        if (to_b) q_b.push_back(32'hFFFF_FFFF); else q_a.push_back(32'hFFFF_FFFF);
    endtask

    // Receiver models: shift in sda on every sck rise, compare each completed word.
    logic [31:0] mon_word_a, mon_word_b;
    int          mon_bits_a, mon_bits_b;
    int          rise_cnt_b = 0;
    int          done_cnt_a = 0;

    always @(posedge sck_a or negedge rst_n) begin
        if (!rst_n) begin
            mon_bits_a = 0;
            mon_word_a = '0;
        end else begin
            mon_word_a = {mon_word_a[30:0], sda_a};
            mon_bits_a++;
            if (mon_bits_a == 32) begin
                mon_bits_a = 0;
                if (q_a.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_a_unexpected: got word %h with nothing expected", mon_word_a);
                end else begin
                    check("sda_word_a", mon_word_a, q_a.pop_front());
                end
            end
        end
    end

    always @(posedge sck_b or negedge rst_n) begin
        if (!rst_n) begin
            mon_bits_b = 0;
            mon_word_b = '0;
        end else begin
            rise_cnt_b++;
            mon_word_b = {mon_word_b[30:0], sda_b};
            mon_bits_b++;
            if (mon_bits_b == 32) begin
                mon_bits_b = 0;
                if (q_b.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_b_unexpected: got word %h with nothing expected", mon_word_b);
                end else begin
                    check("sda_word_b", mon_word_b, q_b.pop_front());
                end
            end
        end
    end

    always @(negedge clk) if (done_a) done_cnt_a++;

    task automatic xfer_a(input logic [223:0] d, input bit inject);
        int j;
        int busy_cycles;
        int done_before;
        int seen_busy;
        done_before = done_cnt_a;
        @(negedge clk);
        data_a  = d;
        start_a = 1'b1;
        push_frame(d, 1'b0);
        @(negedge clk);
        start_a = 1'b0;
        if (inject) data_a = '1;
        check("accept_busy", 32'(busy_a), 32'd1);
        check("accept_sck_sda", 32'({sck_a, sda_a}), 32'd0);
        j = 0;
        busy_cycles = 0;
        while (busy_a && j < 3000) begin
            if (j == A_DIV - 1) check("sck_low_before_rise", 32'(sck_a), 32'd0);
            if (j == A_DIV)     check("first_sck_rise", 32'(sck_a), 32'd1);
            if (inject && j == 300) start_a = 1'b1;
            if (inject && j == 301) start_a = 1'b0;
            busy_cycles++;
            j++;
            @(negedge clk);
        end
        check("busy_cycles_a", 32'(busy_cycles), 32'(576 * A_DIV));
        check("done_pulse_a", 32'(done_a), 32'd1);
        check("idle_outputs_a", 32'({busy_a, sck_a, sda_a}), 32'd0);
        @(negedge clk);
        #1;
        check("done_single_a", 32'(done_a), 32'd0);
        check("done_count_a", 32'(done_cnt_a - done_before), 32'd1);
        check("sb_drain_a", 32'(q_a.size()), 32'd0);
        if (inject) begin
            seen_busy = 0;
            repeat (20) begin
                @(negedge clk);
                if (busy_a || sck_a) seen_busy++;
            end
            check("no_second_xfer", 32'(seen_busy), 32'd0);
        end
    endtask

    typedef struct {
        logic [223:0] data;
        bit           inject;
    } vec_t;

    vec_t         vecs[4];
    logic [223:0] rnd, d1, d2;
    int           bad, cyc, j, rb0;

    initial begin
        for (int i = 0; i < 7; i++) rnd[32*i +: 32] = $urandom();
        vecs[0] = '{data: {7{32'hE0FF_0000}}, inject: 1'b0};
        vecs[1] = '{data: 224'h0,             inject: 1'b0};
        vecs[2] = '{data: {7{32'h1234_5678}}, inject: 1'b1};
        vecs[3] = '{data: rnd,                inject: 1'b0};

        rst_n = 1'b0;
        data_a = '0; data_b = '0;
        start_a = 1'b0; start_b = 1'b0;
        repeat (3) @(negedge clk);
        check("in_reset_outputs", 32'({busy_a, done_a, sck_a, sda_a, busy_b, done_b, sck_b, sda_b}), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if ({busy_a, done_a, sck_a, sda_a, busy_b, done_b, sck_b, sda_b} != 8'd0) bad++;
        end
        check("reset_idle", 32'(bad), 32'd0);

        for (int v = 0; v < 4; v++) xfer_a(vecs[v].data, vecs[v].inject);

        // Back-to-back with start held high at CLK_DIV=1; second payload latched at re-acceptance.
        for (int i = 0; i < 7; i++) begin
            d1[32*i +: 32] = $urandom();
            d2[32*i +: 32] = $urandom();
        end
        rb0 = rise_cnt_b;
        @(negedge clk);
        data_b  = d1;
        start_b = 1'b1;
        push_frame(d1, 1'b1);
        push_frame(d2, 1'b1);
        @(negedge clk);
        data_b = d2;
        check("b2b_accept", 32'(busy_b), 32'd1);
        cyc = 0; j = 0;
        while (busy_b && j < 2000) begin
            cyc++; j++;
            @(negedge clk);
        end
        check("b2b_busy1", 32'(cyc), 32'(576 * B_DIV));
        check("b2b_done1", 32'({done_b, busy_b}), 32'b10);
        @(negedge clk);
        check("b2b_restart", 32'({done_b, busy_b}), 32'b01);
        start_b = 1'b0;
        cyc = 0; j = 0;
        while (busy_b && j < 2000) begin
            cyc++; j++;
            @(negedge clk);
        end
        check("b2b_busy2", 32'(cyc), 32'(576 * B_DIV));
        check("b2b_done2", 32'(done_b), 32'd1);
        @(negedge clk);
        check("b2b_rises", 32'(rise_cnt_b - rb0), 32'd576);
        check("sb_drain_b", 32'(q_b.size()), 32'd0);

        // Reset around bit 100 of a transfer, then a fresh full frame.
        @(negedge clk);
        data_a  = {7{32'hCAFE_F00D}};
        start_a = 1'b1;
        push_frame(data_a, 1'b0);
        @(negedge clk);
        start_a = 1'b0;
        repeat (100 * 2 * A_DIV + 1) @(negedge clk);
        check("mid_busy_before_reset", 32'(busy_a), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'({busy_a, done_a, sck_a, sda_a}), 32'd0);
        q_a.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if ({busy_a, sck_a, sda_a} != 3'd0) bad++;
        end
        check("no_resume_after_reset", 32'(bad), 32'd0);
        xfer_a({7{32'h0F0F_A5A5}}, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
